// File: rtl/drw_wrtfifo_burst_if.sv
// FIFO-read and AXI4 W-channel signals of the draw write-data adapter.
// The master modport is the adapter side; slave is the FIFO/interconnect side.
interface drw_wrtfifo_burst_if #(
  parameter int unsigned DATA_W = 32
);
  logic              EMPTY;
  logic              RD;
  logic              VALID;
  logic [DATA_W-1:0] DOUT;
  logic              WREADY;
  logic              WVALID;
  logic [DATA_W-1:0] WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic              WLAST;

  modport master (
    input  EMPTY, VALID, DOUT, WREADY,
    output RD, WVALID, WDATA, WSTRB, WLAST
  );

  modport slave (
    output EMPTY, VALID, DOUT, WREADY,
    input  RD, WVALID, WDATA, WSTRB, WLAST
  );
endinterface

// File: rtl/drw_wrtfifo_burst.sv
// Write-FIFO to AXI4 W-channel adapter: 2-entry prefetch, fixed-length bursts, one per AW credit.
// Define DRW_WRT_PAD_EN to zero-pad an incomplete final burst after WRT_FIN (S_PAD).
module drw_wrtfifo_burst #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned CRED_W    = 3
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic CLR,
  input  logic AW_ACK,
  input  logic WRT_FIN,
  drw_wrtfifo_burst_if.master bus,
  output logic BUSY,
  output logic OVF
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
`ifdef DRW_WRT_PAD_EN
  localparam logic [1:0] S_PAD   = 2'd2;
`endif

  localparam int unsigned     BC_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BURST_LEN - 1);
  localparam logic [CRED_W-1:0] CRED_MAX = '1;

  logic [1:0]        state;
  logic [DATA_W-1:0] mem [2];
  logic              hd;
  logic [1:0]        occ;
  logic              in_flight;
  logic              drop;
  logic [CRED_W-1:0] credits;
  logic [CRED_W-1:0] cred_nx;
  logic [BC_W-1:0]   beat_cnt;
  logic              fin_pend;

  logic beat, last_hs, pop, push, cred_inc, is_last;

  assign beat    = bus.WVALID && bus.WREADY;
  assign last_hs = beat && bus.WLAST;
  assign pop     = beat && (state == S_BURST);
  assign push    = bus.VALID && !drop;
  assign is_last = (beat_cnt == LAST_BEAT);

  // The same-cycle pop is counted as free space so a draining buffer refills
  // without a bubble; occupancy + in_flight still never exceeds 2.
  assign bus.RD = ARESETN && !CLR && !bus.EMPTY &&
                  ((3'(occ) + 3'(in_flight)) < (3'd2 + 3'(pop)));

  assign cred_inc = AW_ACK && ((credits != CRED_MAX) || last_hs);
  assign cred_nx  = credits + CRED_W'(cred_inc) - CRED_W'(last_hs);

  assign BUSY = (state != S_IDLE) || (credits != '0);

`ifdef DRW_WRT_PAD_EN
  logic to_pad;
  assign to_pad = (state == S_BURST) && fin_pend && (beat_cnt != '0) &&
                  (occ == 2'd0) && !in_flight && bus.EMPTY;
`else
  logic unused_fin;
  assign unused_fin = WRT_FIN ^ fin_pend;
`endif

  always_comb begin
    bus.WVALID = 1'b0;
    bus.WDATA  = '0;
    bus.WSTRB  = '0;
    bus.WLAST  = 1'b0;
    case (state)
      S_BURST: begin
        bus.WVALID = (occ != 2'd0);
        bus.WDATA  = mem[hd];
        bus.WSTRB  = '1;
        bus.WLAST  = is_last;
      end
`ifdef DRW_WRT_PAD_EN
      S_PAD: begin
        bus.WVALID = 1'b1;
        bus.WLAST  = is_last;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN || CLR) begin
      state     <= S_IDLE;
      hd        <= 1'b0;
      occ       <= 2'd0;
      in_flight <= 1'b0;
      drop      <= 1'b1;
      credits   <= '0;
      beat_cnt  <= '0;
      fin_pend  <= 1'b0;
      OVF       <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      if (push) mem[hd ^ occ[0]] <= bus.DOUT;
      if (pop) hd <= ~hd;
      occ       <= occ + 2'(push) - 2'(pop);
      in_flight <= bus.RD;
      drop      <= 1'b0;
      credits   <= cred_nx;
      if (AW_ACK && (credits == CRED_MAX) && !last_hs) OVF <= 1'b1;
      if (beat) beat_cnt <= is_last ? '0 : beat_cnt + 1'b1;

      case (state)
        S_IDLE:
          if (credits != '0) state <= S_BURST;
        S_BURST: begin
          if (last_hs && (cred_nx == '0)) state <= S_IDLE;
`ifdef DRW_WRT_PAD_EN
          else if (to_pad) state <= S_PAD;
`endif
        end
`ifdef DRW_WRT_PAD_EN
        S_PAD:
          if (last_hs) state <= (cred_nx != '0) ? S_BURST : S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase

`ifdef DRW_WRT_PAD_EN
      if (to_pad) fin_pend <= 1'b0;
      else if (WRT_FIN) fin_pend <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_drw_wrtfifo_burst.sv
// Scoreboard bench for drw_wrtfifo_burst: BURST_LEN=4, CRED_W=2, 32-bit data.
module tb_drw_wrtfifo_burst;
  localparam int unsigned DW = 32;
  localparam int unsigned BL = 4;
  localparam int unsigned CW = 2;

  typedef struct packed {
    logic [DW-1:0]   d;
    logic [DW/8-1:0] s;
    logic            l;
  } beat_t;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic CLR = 1'b0;
  logic AW_ACK = 1'b0;
  logic WRT_FIN = 1'b0;
  logic BUSY, OVF;

  drw_wrtfifo_burst_if #(.DATA_W(DW)) bus ();

  drw_wrtfifo_burst #(.DATA_W(DW), .BURST_LEN(BL), .CRED_W(CW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .CLR(CLR), .AW_ACK(AW_ACK),
    .WRT_FIN(WRT_FIN), .bus(bus), .BUSY(BUSY), .OVF(OVF)
  );

  always #5 ACLK = ~ACLK;

  beat_t         exp_q[$];
  logic [DW-1:0] fifo_q[$];
  int            beat_cyc[$];
  int total = 0, bad = 0;
  int rd_total = 0, pf = 0, cyc = 0;
  logic rd_neg = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic samp();
    @(negedge ACLK);
  endtask

  task automatic pulse_ack();
    AW_ACK = 1'b1; tick(); AW_ACK = 1'b0;
  endtask

  task automatic add_word(input logic [DW-1:0] d, input logic [DW/8-1:0] s, input logic l);
    beat_t e;
    e.d = d; e.s = s; e.l = l;
    exp_q.push_back(e);
    if (s != '0) fifo_q.push_back(d);
  endtask

  task automatic wait_drain(input string nm, input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  // FIFO model: VALID/DOUT one cycle after a sampled RD.
  initial begin
    bus.EMPTY = 1'b1; bus.VALID = 1'b0; bus.DOUT = '0;
    forever begin
      @(posedge ACLK); #2;
      if (rd_neg) begin
        chk("fifo_underflow", 64'(fifo_q.size() != 0), 64'd1);
        bus.VALID = 1'b1;
        if (fifo_q.size() != 0) bus.DOUT = fifo_q.pop_front();
      end else begin
        bus.VALID = 1'b0;
      end
      bus.EMPTY = (fifo_q.size() == 0);
    end
  end

  // Monitor: beats scored against the expected queue, prefetch depth tracked.
  always @(negedge ACLK) begin
    beat_t e;
    cyc++;
    rd_neg = bus.RD;
    if (bus.WVALID && bus.WREADY) begin
      beat_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_beat: got data %0h, no beat expected", bus.WDATA);
      end else begin
        e = exp_q.pop_front();
        chk("wdata", 64'(bus.WDATA), 64'(e.d));
        chk("wstrb", 64'(bus.WSTRB), 64'(e.s));
        chk("wlast", 64'(bus.WLAST), 64'(e.l));
        if (e.s != '0) pf--;
      end
    end
    if (bus.RD) begin
      rd_total++;
      pf++;
      chk("prefetch_space", 64'(pf <= 2), 64'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, base;
    logic [DW-1:0] bp_words [8];
    bp_words = '{32'h0badf00d, 32'h12345678, 32'hcafebabe, 32'h00000001,
                 32'hffffffff, 32'h80000000, 32'h7fffffff, 32'h5555aaaa};
    bus.WREADY = 1'b0;

    // Reset held with FIFO data present
    add_word(32'h11, 4'hF, 1'b0);
    add_word(32'h22, 4'hF, 1'b0);
    add_word(32'h33, 4'hF, 1'b0);
    add_word(32'h44, 4'hF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      samp();
      chk("rst_rd", 64'(bus.RD), 64'd0);
      chk("rst_wvalid", 64'(bus.WVALID), 64'd0);
      chk("rst_busy", 64'(BUSY), 64'd0);
    end
    tick();
    ARESETN = 1'b1;
    r0 = rd_total;
    repeat (6) tick();
    chk("prefetch_two", 64'(rd_total - r0), 64'd2);
    samp();
    chk("idle_busy", 64'(BUSY), 64'd0);
    chk("idle_wvalid", 64'(bus.WVALID), 64'd0);

    // Single burst and credit-to-WVALID latency
    tick();
    bus.WREADY = 1'b1;
    AW_ACK = 1'b1;
    samp();
    chk("ack_cycle_wvalid", 64'(bus.WVALID), 64'd0);
    tick();
    AW_ACK = 1'b0;
    samp();
    chk("credit_cycle_wvalid", 64'(bus.WVALID), 64'd0);
    chk("credit_cycle_busy", 64'(BUSY), 64'd1);
    tick();
    samp();
    chk("burst_wvalid", 64'(bus.WVALID), 64'd1);
    tick();
    wait_drain("single_drain", 20);
    tick(); samp();
    chk("single_end_busy", 64'(BUSY), 64'd0);

    // Backpressure over two bursts, buffer-full RD gating
    tick();
    bus.WREADY = 1'b0;
    for (int i = 0; i < 8; i++) add_word(bp_words[i], 4'hF, (i % 4) == 3);
    pulse_ack();
    pulse_ack();
    repeat (4) tick();
    samp();
    chk("full_no_rd", 64'(bus.RD), 64'd0);
    chk("full_wvalid", 64'(bus.WVALID), 64'd1);
    chk("bp_busy", 64'(BUSY), 64'd1);
    tick();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      bus.WREADY = (i % 2) == 0;
      tick();
    end
    chk("bp_drain", 64'(exp_q.size()), 64'd0);
    bus.WREADY = 1'b1;
    repeat (2) tick();
    samp();
    chk("bp_end_busy", 64'(BUSY), 64'd0);

    // Back-to-back bursts; third AW_ACK coincides with the first WLAST
    tick();
    base = beat_cyc.size();
    for (int i = 0; i < 12; i++) add_word(32'h1000 + i, 4'hF, (i % 4) == 3);
    pulse_ack();
    pulse_ack();
    for (int i = 0; i < 40 && beat_cyc.size() < base + 3; i++) tick();
    AW_ACK = 1'b1; tick(); AW_ACK = 1'b0;
    wait_drain("b2b_drain", 40);
    if (beat_cyc.size() >= base + 12)
      chk("b2b_gap", 64'(beat_cyc[base+11] - beat_cyc[base]), 64'd11);
    else begin
      total++; bad++;
      $display("FAIL b2b_count: got %0d beats expected 12", beat_cyc.size() - base);
    end
    tick(); samp();
    chk("b2b_credits_zero", 64'(BUSY), 64'd0);

    // Credit overflow, then CLR with a word in flight
    tick();
    repeat (3) pulse_ack();
    samp();
    chk("ovf_at_max", 64'(OVF), 64'd0);
    tick();
    pulse_ack();
    samp();
    chk("ovf_set", 64'(OVF), 64'd1);
    chk("ovf_busy", 64'(BUSY), 64'd1);
    chk("ovf_no_data", 64'(bus.WVALID), 64'd0);
    tick();
    fifo_q.push_back(32'hbad0bad0);
    samp();
    chk("rd_before_clr", 64'(bus.RD), 64'd1);
    tick();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    pf = 0;
    samp();
    chk("clr_ovf", 64'(OVF), 64'd0);
    chk("clr_busy", 64'(BUSY), 64'd0);
    chk("clr_wvalid", 64'(bus.WVALID), 64'd0);
    tick();
    add_word(32'h2000, 4'hF, 1'b0);
    add_word(32'h2001, 4'hF, 1'b0);
    add_word(32'h2002, 4'hF, 1'b0);
    add_word(32'h2003, 4'hF, 1'b1);
    pulse_ack();
    wait_drain("post_clr_drain", 30);
    tick(); samp();
    chk("post_clr_busy", 64'(BUSY), 64'd0);

    // Short final burst after WRT_FIN
    tick();
    add_word(32'h5a, 4'hF, 1'b0);
    add_word(32'h5b, 4'hF, 1'b0);
`ifdef DRW_WRT_PAD_EN
    add_word(32'h0, 4'h0, 1'b0);
    add_word(32'h0, 4'h0, 1'b1);
`endif
    WRT_FIN = 1'b1;
    pulse_ack();
    WRT_FIN = 1'b0;
    wait_drain("fin_drain", 30);
`ifdef DRW_WRT_PAD_EN
    tick(); samp();
    chk("pad_end_busy", 64'(BUSY), 64'd0);
`else
    repeat (5) tick();
    samp();
    chk("nopad_wvalid", 64'(bus.WVALID), 64'd0);
    chk("nopad_busy", 64'(BUSY), 64'd1);
    tick();
    CLR = 1'b1; tick(); CLR = 1'b0;
    samp();
    chk("nopad_clr_busy", 64'(BUSY), 64'd0);
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
